// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU results against LSU load responses, aligns and
// extends load data, registers the regfile write port and tracks pending loads.
module wb_stage #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        alu_valid_i,
  output logic        alu_ready_o,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [1:0]  lsu_offset_i,
  input  logic [31:0] lsu_raw_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  output logic        rd_wren,
  output logic [5:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] busy_o,
  output logic        err_o
);

  localparam int unsigned CntW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STARVE_MAX - 1);

  typedef enum logic [0:0] {StAluPri, StLsuPri} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        alu_acc, lsu_acc;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic        load_illegal;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [31:0] busy_d;

  // Arbitration state and starvation counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StAluPri;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: LSU gets one priority cycle after STARVE_MAX straight losses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StAluPri: begin
        if (alu_valid_i && lsu_valid_i) begin
          if (cnt_q == CntLast) begin
            state_d = StLsuPri;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // Streak of losses is broken whenever the LSU is idle or wins.
          cnt_d = '0;
        end
      end
      StLsuPri: begin
        state_d = StAluPri;
        cnt_d   = '0;
      end
      default: begin
        state_d = StAluPri;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake outputs: the priority source is always ready.
  always_comb begin
    alu_ready_o = 1'b1;
    lsu_ready_o = !alu_valid_i;
    if (state_q == StLsuPri) begin
      lsu_ready_o = 1'b1;
      alu_ready_o = !lsu_valid_i;
    end
    alu_acc = alu_valid_i && alu_ready_o;
    lsu_acc = lsu_valid_i && lsu_ready_o;
  end

  // Load alignment and sign/zero extension.
  always_comb begin
    unique case (lsu_offset_i)
      2'd0:    load_byte = lsu_raw_i[7:0];
      2'd1:    load_byte = lsu_raw_i[15:8];
      2'd2:    load_byte = lsu_raw_i[23:16];
      default: load_byte = lsu_raw_i[31:24];
    endcase
    load_half    = lsu_offset_i[1] ? lsu_raw_i[31:16] : lsu_raw_i[15:0];
    load_illegal = 1'b0;
    unique case (lsu_funct3_i)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b010:  load_data = lsu_raw_i;
      3'b100:  load_data = {24'h0, load_byte};
      3'b101:  load_data = {16'h0, load_half};
      default: begin
        load_data    = lsu_raw_i;
        load_illegal = 1'b1;
      end
    endcase
  end

  // Select the accepted source; x0 writes are dropped.
  always_comb begin
    wr_rd   = alu_acc ? alu_rd_i : lsu_rd_i;
    wr_data = alu_acc ? alu_data_i : load_data;
    wr_en   = (alu_acc || lsu_acc) && (wr_rd != 5'd0);
  end

  // Registered regfile write port; address/data hold when nothing is written.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_wren <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
      err_o   <= 1'b0;
    end else begin
      rd_wren <= wr_en;
      err_o   <= lsu_acc && load_illegal;
      if (wr_en) begin
        rd_addr <= {1'b0, wr_rd};
        rd_data <= wr_data;
      end
    end
  end

  // Pending-load scoreboard: clear on response, then set on issue so set wins.
  always_comb begin
    busy_d = busy_o;
    if (lsu_acc) begin
      busy_d[lsu_rd_i] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != 5'd0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_o <= '0;
    end else begin
      busy_o <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected post-edge outputs,
// a monitor pops and compares them on every falling edge.
module tb_wb_stage;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        alu_valid_i, alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i, lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [2:0]  lsu_funct3_i;
  logic [1:0]  lsu_offset_i;
  logic [31:0] lsu_raw_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        rd_wren;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] busy_o;
  logic        err_o;

  always #5 clk = ~clk;

  wb_stage #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .alu_valid_i  (alu_valid_i),
    .alu_ready_o  (alu_ready_o),
    .alu_rd_i     (alu_rd_i),
    .alu_data_i   (alu_data_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_rd_i     (lsu_rd_i),
    .lsu_funct3_i (lsu_funct3_i),
    .lsu_offset_i (lsu_offset_i),
    .lsu_raw_i    (lsu_raw_i),
    .issue_valid_i(issue_valid_i),
    .issue_rd_i   (issue_rd_i),
    .rd_wren      (rd_wren),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  typedef struct {
    logic        wren;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: whose turn it is and how many straight losses the LSU has.
  bit          lsu_turn;
  int          lsu_losses;
  bit          pend[32];
  logic [5:0]  m_addr;
  logic [31:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] raw);
    logic [31:0] b, h;
    b = (raw >> (int'(off) * 8)) & 32'hFF;
    h = (raw >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return raw;
    endcase
  endfunction

  function automatic bit legal_f3(input logic [2:0] f3);
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  // Monitor: one expected entry is pushed per clock edge; compare it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("rd_wren", {31'h0, rd_wren}, {31'h0, e.wren});
        check("err_o", {31'h0, err_o}, {31'h0, e.err});
        check("busy_o", busy_o, e.busy);
        check("rd_addr", {26'h0, rd_addr}, {26'h0, e.addr});
        check("rd_data", rd_data, e.data);
      end
    end
  end

  // One clock: model the inputs currently driven, check readies, push expectation.
  task automatic step(output bit a_acc, output bit l_acc);
    exp_t        e;
    logic [4:0]  rd;
    logic [31:0] wd;
    bit          exp_ar, exp_lr;
    #1;
    a_acc = 0;
    l_acc = 0;
    if (!rst_ni) begin
      lsu_turn   = 0;
      lsu_losses = 0;
      foreach (pend[i]) pend[i] = 0;
      m_addr = '0;
      m_data = '0;
      e.wren = 0;
      e.err  = 0;
    end else begin
      exp_ar = lsu_turn ? !lsu_valid_i : 1'b1;
      exp_lr = lsu_turn ? 1'b1 : !alu_valid_i;
      check("alu_ready_o", {31'h0, alu_ready_o}, {31'h0, exp_ar});
      check("lsu_ready_o", {31'h0, lsu_ready_o}, {31'h0, exp_lr});
      a_acc = alu_valid_i && exp_ar;
      l_acc = lsu_valid_i && exp_lr;
      rd    = a_acc ? alu_rd_i : lsu_rd_i;
      wd    = a_acc ? alu_data_i : ref_load(lsu_funct3_i, lsu_offset_i, lsu_raw_i);
      e.wren = (a_acc || l_acc) && rd != 0;
      e.err  = l_acc && !legal_f3(lsu_funct3_i);
      if (e.wren) begin
        m_addr = {1'b0, rd};
        m_data = wd;
      end
      if (l_acc) pend[lsu_rd_i] = 0;
      if (issue_valid_i && issue_rd_i != 0) pend[issue_rd_i] = 1;
      if (lsu_turn) begin
        lsu_turn   = 0;
        lsu_losses = 0;
      end else if (alu_valid_i && lsu_valid_i) begin
        lsu_losses++;
        if (lsu_losses == STARVE_MAX) begin
          lsu_turn   = 1;
          lsu_losses = 0;
        end
      end else begin
        lsu_losses = 0;
      end
    end
    e.addr = m_addr;
    e.data = m_data;
    for (int i = 0; i < 32; i++) e.busy[i] = pend[i];
    @(posedge clk);
    expq.push_back(e);
    #1;
  endtask

  task automatic set_alu(input bit v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid_i = v;
    alu_rd_i    = rd;
    alu_data_i  = d;
  endtask

  task automatic set_lsu(input bit v, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] off, input logic [31:0] raw);
    lsu_valid_i  = v;
    lsu_rd_i     = rd;
    lsu_funct3_i = f3;
    lsu_offset_i = off;
    lsu_raw_i    = raw;
  endtask

  // Replace accepted/idle transactions with fresh random ones; pending ones hold.
  task automatic refill(input bit a_acc, input bit l_acc, input int pct);
    logic [2:0] f3s[8];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b011, 3'b111};
    if (a_acc || !alu_valid_i)
      set_alu($urandom_range(0, 99) < pct, 5'($urandom_range(0, 31)), $urandom);
    if (l_acc || !lsu_valid_i)
      set_lsu($urandom_range(0, 99) < pct, 5'($urandom_range(0, 31)),
              f3s[$urandom_range(0, 7)], 2'($urandom_range(0, 3)), $urandom);
    issue_valid_i = $urandom_range(0, 99) < 40;
    issue_rd_i    = ($urandom_range(0, 3) == 0) ? lsu_rd_i : 5'($urandom_range(0, 31));
  endtask

  initial begin
    bit aa, la;
    rst_ni        = 0;
    issue_valid_i = 0;
    issue_rd_i    = 0;
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0, 0, 0);
    step(aa, la);
    step(aa, la);
    rst_ni = 1;

    // Directed writes and load formats.
    set_alu(1, 5, 32'h0000_1234);            step(aa, la);
    set_alu(1, 0, 32'hFFFF_FFFF);            step(aa, la);
    set_alu(0, 0, 0);
    set_lsu(1, 3, 3'b000, 2'd1, 32'h0000_8000); step(aa, la);
    set_lsu(1, 4, 3'b101, 2'd2, 32'hBEEF_0000); step(aa, la);
    set_lsu(1, 6, 3'b011, 2'd0, 32'hA5A5_A5A5); step(aa, la);
    set_lsu(0, 0, 0, 0, 0);                  step(aa, la);

    // Scoreboard: set, clear with simultaneous re-issue, then clear.
    issue_valid_i = 1; issue_rd_i = 7;       step(aa, la);
    set_lsu(1, 7, 3'b010, 2'd0, 32'h1111_2222); step(aa, la);
    issue_valid_i = 0;
    set_lsu(1, 7, 3'b010, 2'd0, 32'h3333_4444); step(aa, la);
    set_lsu(0, 0, 0, 0, 0);                  step(aa, la);

    // Sustained contention, then reset in the middle of a second run.
    for (int i = 0; i < 12; i++) begin
      refill(aa, la, 100);
      issue_valid_i = 0;
      step(aa, la);
    end
    for (int i = 0; i < 2; i++) begin
      refill(aa, la, 100);
      step(aa, la);
    end
    rst_ni = 0;
    step(aa, la);
    rst_ni = 1;
    for (int i = 0; i < 8; i++) begin
      refill(aa, la, 100);
      step(aa, la);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      refill(aa, la, (i < 1500) ? 70 : 95);
      rst_ni = ($urandom_range(0, 249) != 0);
      step(aa, la);
    end
    rst_ni = 1;
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0, 0, 0);
    issue_valid_i = 0;
    step(aa, la);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
